// File: rtl/cpu_jtag_debug_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
// Contents: scan FSM state enum, virtual IR codes understood by the debug
// module, and the default DR scan length.
package cpu_jtag_debug_pkg;

    localparam int unsigned DrWidthDefault = 38;

    // Virtual IR codes of the CPU debug module (passed through, never decoded here)
    localparam logic [1:0] IrOcimem    = 2'd0;
    localparam logic [1:0] IrTracemem  = 2'd1;
    localparam logic [1:0] IrBreak     = 2'd2;
    localparam logic [1:0] IrTracectrl = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StRsp
    } scan_state_e;

endpackage

// File: rtl/cpu_jtag_tck_gen.sv
// Test-clock generator for the scan master.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   run           1 = generate tck; 0 = hold tck low and clear the phase
//   tck           generated test clock (TCK_DIV clks low, TCK_DIV clks high)
//   rise          high on the clk whose edge drives tck 0->1
//   fall          high on the clk whose edge drives tck 1->0
module cpu_jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tck_q, tck_d;
    logic            edge_due;

    // Last clk of a half-period: the coming edge toggles tck
    assign edge_due = run && (cnt_q == CntW'(TCK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (edge_due) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck  = tck_q;
    assign rise = edge_due && !tck_q;
    assign fall = edge_due && tck_q;

endmodule

// File: rtl/cpu_jtag_debug_scan_master.sv
// Virtual-JTAG scan master for the CPU debug module.
// Accepts {IR, DR} on a valid/ready port, plays UIR, CDR, DR_WIDTH x SDR, UDR
// and returns the captured tdo bits as a one-clk response.
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_ir, cmd_dr                instruction and data (data shifted LSB first)
//   rsp_valid, rsp_dr             one-clk response pulse, captured bits (held)
//   busy                          accept through response cycle
//   vji_tck/tdi/tdo               scan clock and serial data
//   vji_ir_in                     latched instruction, held between scans
//   vji_rti, vji_uir/cdr/sdr/udr  virtual state indicators
module cpu_jtag_debug_scan_master
    import cpu_jtag_debug_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DrWidthDefault,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int unsigned CntW = $clog2(DR_WIDTH + 1);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                run, tck_rise, tck_fall, accept;

    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic                tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                rti_q, rti_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d;

    assign accept = cmd_valid && (state_q == StIdle);
    assign run    = (state_q == StUir) || (state_q == StCdr) ||
                    (state_q == StSdr) || (state_q == StUdr);

    cpu_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tck     (vji_tck),
        .rise    (tck_rise),
        .fall    (tck_fall)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: scan states advance only at tck fall
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)   state_d = StUir;
            StUir:   if (tck_fall) state_d = StCdr;
            StCdr:   if (tck_fall) state_d = StSdr;
            StSdr:   if (tck_fall && (bit_cnt_q == CntW'(DR_WIDTH))) state_d = StUdr;
            StUdr:   if (tck_fall) state_d = StRsp;
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shift register and bit counter: tdo is captured on the clk tck rises
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            sr_d      = cmd_dr;
            bit_cnt_d = '0;
        end else if ((state_q == StSdr) && tck_rise) begin
            sr_d      = DR_WIDTH'({vji_tdo, sr_q} >> 1);
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs, decoded from the next state so they register in step with it
    always_comb begin
        rti_d       = (state_d == StIdle);
        uir_d       = (state_d == StUir);
        cdr_d       = (state_d == StCdr);
        sdr_d       = (state_d == StSdr);
        udr_d       = (state_d == StUdr);
        rsp_valid_d = (state_d == StRsp);
        rsp_dr_d    = (state_d == StRsp) ? sr_q : rsp_dr_q;
        ir_d        = accept ? cmd_ir : ir_q;
        // tdi only moves at tck fall so it is stable for the whole low+rise
        tdi_d       = tdi_q;
        if (tck_fall) begin
            tdi_d = (state_d == StSdr) ? sr_q[0] : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_dr_q    <= '0;
            tdi_q       <= 1'b0;
            ir_q        <= '0;
            rti_q       <= 1'b1;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_dr_q    <= rsp_dr_d;
            tdi_q       <= tdi_d;
            ir_q        <= ir_d;
            rti_q       <= rti_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dr    = rsp_dr_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_rti   = rti_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;

endmodule
